// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: constants shared by the CPU memory controller.
//   mc_state_e    - controller FSM states (IDLE, IFETCH, LOAD, STORE)
//   LS_SIZE_*     - ls_size encodings (3 is treated as a word access)
//   size_to_len() - number of bytes moved for a given ls_size
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        LOAD   = 2'd2,
        STORE  = 2'd3
    } mc_state_e;

    localparam logic [1:0] LS_SIZE_BYTE  = 2'd0;
    localparam logic [1:0] LS_SIZE_HALF  = 2'd1;
    localparam logic [1:0] LS_SIZE_WORD  = 2'd2;
    localparam logic [1:0] LS_SIZE_WORD3 = 2'd3;

    localparam logic [2:0] WORD_BYTES = 3'd4;

    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            LS_SIZE_BYTE: size_to_len = 3'd1;
            LS_SIZE_HALF: size_to_len = 3'd2;
            default:      size_to_len = WORD_BYTES;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller arbitrating between the instruction
// fetcher and the load/store unit in front of an 8-bit synchronous RAM.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable, low = hold)
//   if_read_signal/if_pc  -> if_done/if_instr       instruction fetch (4 bytes)
//   ls_valid/ls_wr/ls_size/ls_addr/ls_wdata -> ls_done/ls_rdata  data access
//   mem_din (RAM byte for previous cycle's mem_a), mem_dout, mem_a, mem_wr
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_read_signal,
    input  logic [31:0] if_pc,
    output logic        if_done,
    output logic [31:0] if_instr,
    input  logic        ls_valid,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    mc_state_e   state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;       // index of the byte currently on mem_a
    logic [2:0]  len_q, len_d;       // bytes in this transaction
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;       // read assembly buffer
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        if_done_q, if_done_d;
    logic        ls_done_q, ls_done_d;
    logic        cool_q, cool_d;     // post-done IDLE cycle that refuses requests
    logic        stall_q, stall_d;   // previous edge had rdy_in low
    logic [7:0]  hold_q, hold_d;     // RAM byte caught on the first stalled edge

    logic [7:0]  din_eff;
    logic [1:0]  cap_idx;
    logic [1:0]  nxt_idx;
    logic [31:0] buf_cap;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        if_instr_d = if_instr_q;
        ls_rdata_d = ls_rdata_q;
        if_done_d  = if_done_q;
        ls_done_d  = ls_done_q;
        cool_d     = cool_q;
        stall_d    = stall_q;
        hold_d     = hold_q;

        // While stalled, mem_a is frozen so mem_din drifts to the byte now on
        // mem_a. The byte that was in flight when the stall began is kept in
        // hold_q and consumed on the resume edge, so a stall costs exactly its
        // own length.
        din_eff = stall_q ? hold_q : mem_din;
        cap_idx = 2'(cnt_q - 3'd1);
        nxt_idx = cnt_q[1:0] + 2'd1;
        buf_cap = buf_q;
        buf_cap[{cap_idx, 3'b000} +: 8] = din_eff;

        if (!rdy_in) begin
            if (!stall_q) begin
                hold_d = mem_din;
            end
            stall_d = 1'b1;
        end else begin
            stall_d   = 1'b0;
            if_done_d = 1'b0;
            ls_done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (cool_q) begin
                        cool_d = 1'b0;
                    end else if (ls_valid) begin
                        state_d = ls_wr ? STORE : LOAD;
                        cnt_d   = '0;
                        len_d   = size_to_len(ls_size);
                        mem_a_d = ls_addr;
                        wdata_d = ls_wdata;
                        buf_d   = '0;
                        if (ls_wr) begin
                            mem_wr_d   = 1'b1;
                            mem_dout_d = ls_wdata[7:0];
                        end
                    end else if (if_read_signal) begin
                        state_d = IFETCH;
                        cnt_d   = '0;
                        len_d   = WORD_BYTES;
                        mem_a_d = if_pc;
                        buf_d   = '0;
                    end
                end
                IFETCH, LOAD: begin
                    if (cnt_q != 3'd0) begin
                        buf_d = buf_cap;
                    end
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                        cool_d  = 1'b1;
                        if (state_q == IFETCH) begin
                            if_instr_d = buf_cap;
                            if_done_d  = 1'b1;
                        end else begin
                            ls_rdata_d = buf_cap;
                            ls_done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q + 3'd1 < len_q) begin
                            mem_a_d = mem_a_q + 32'd1;
                        end
                    end
                end
                STORE: begin
                    if (cnt_q + 3'd1 < len_q) begin
                        cnt_d      = cnt_q + 3'd1;
                        mem_a_d    = mem_a_q + 32'd1;
                        mem_dout_d = wdata_q[{nxt_idx, 3'b000} +: 8];
                    end else begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        mem_wr_d  = 1'b0;
                        ls_done_d = 1'b1;
                        cool_d    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            wdata_q    <= '0;
            buf_q      <= '0;
            if_instr_q <= '0;
            ls_rdata_q <= '0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            cool_q     <= 1'b0;
            stall_q    <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            if_instr_q <= if_instr_d;
            ls_rdata_q <= ls_rdata_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            cool_q     <= cool_d;
            stall_q    <= stall_d;
            hold_q     <= hold_d;
        end
    end

    assign if_done  = if_done_q;
    assign if_instr = if_instr_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    // A stalled write byte must not reach the RAM; it is presented again on resume.
    assign mem_wr   = mem_wr_q & rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with a 1 KiB byte RAM
// model (address aliased on mem_a[9:0]) that returns the previous cycle's byte.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        if_read_signal = 1'b0;
    logic [31:0] if_pc = '0;
    logic        if_done;
    logic [31:0] if_instr;
    logic        ls_valid = 1'b0;
    logic        ls_wr = 1'b0;
    logic [1:0]  ls_size = 2'd0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [7:0]  pre_data = '0;
    logic [7:0]  ram [1024];

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [7:0]  st_exp [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [31:0] wrap_a [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    mem_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .if_read_signal (if_read_signal),
        .if_pc          (if_pc),
        .if_done        (if_done),
        .if_instr       (if_instr),
        .ls_valid       (ls_valid),
        .ls_wr          (ls_wr),
        .ls_size        (ls_size),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_done        (ls_done),
        .ls_rdata       (ls_rdata),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (pre_we)
            ram[pre_addr] <= pre_data;
        else if (mem_wr)
            ram[mem_a[9:0]] <= mem_dout;
        mem_din <= ram[mem_a[9:0]];
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    // Ticks until the selected done pulse appears (bounded), then checks the
    // number of cycles taken and optionally the returned data.
    task automatic wait_done(input bit want_if, input int unsigned exp_cyc,
                             input bit chk_data, input logic [31:0] exp_data,
                             input string tag);
        int unsigned cyc = 0;
        bit seen = 1'b0;
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            seen = want_if ? if_done : ls_done;
        end
        check({tag, "_cyc"}, cyc, exp_cyc);
        if (chk_data)
            check({tag, "_data"}, want_if ? if_instr : ls_rdata, exp_data);
    endtask

    initial begin
        // Reset, with RAM preload happening underneath it
        preload(10'h100, 8'h13);
        preload(10'h101, 8'h05);
        preload(10'h102, 8'h10);
        preload(10'h103, 8'h00);
        preload(10'h3FE, 8'hAA);
        preload(10'h3FF, 8'hBB);
        preload(10'h000, 8'hCC);
        preload(10'h001, 8'hDD);
        preload(10'h343, 8'h55);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_mem_dout", mem_dout, 8'h00);
        check("rst_if_done", if_done, 1'b0);
        check("rst_ls_done", ls_done, 1'b0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_ls_rdata", ls_rdata, 32'h0);
        rst_in = 1'b0;
        tick();

        // Word fetch at 0x100
        if_pc = 32'h100;
        if_read_signal = 1'b1;
        wait_done(1'b1, 6, 1'b1, 32'h0010_0513, "fetch");
        if_read_signal = 1'b0;
        tick();
        check("fetch_pulse_end", if_done, 1'b0);

        // Store word 0xDEADBEEF at 0x200
        ls_valid = 1'b1; ls_wr = 1'b1; ls_size = 2'd2;
        ls_addr = 32'h200; ls_wdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("st_wr", mem_wr, 1'b1);
            check("st_a", mem_a, 32'h200 + k);
            check("st_dout", mem_dout, st_exp[k]);
        end
        tick();
        check("st_done", ls_done, 1'b1);
        check("st_wr_off", mem_wr, 1'b0);
        ls_valid = 1'b0;
        tick();
        check("st_ram0", ram[10'h200], 8'hEF);
        check("st_ram3", ram[10'h203], 8'hDE);

        // Load word / byte / half back
        ls_valid = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h200;
        wait_done(1'b0, 6, 1'b1, 32'hDEAD_BEEF, "ld_word");
        ls_valid = 1'b0; tick();
        ls_valid = 1'b1; ls_size = 2'd0; ls_addr = 32'h203;
        wait_done(1'b0, 3, 1'b1, 32'h0000_00DE, "ld_byte");
        ls_valid = 1'b0; tick();
        ls_valid = 1'b1; ls_size = 2'd1; ls_addr = 32'h202;
        wait_done(1'b0, 4, 1'b1, 32'h0000_DEAD, "ld_half");
        ls_valid = 1'b0; tick();
        check("if_instr_hold", if_instr, 32'h0010_0513);

        // Simultaneous requests: data first, then instruction
        ls_valid = 1'b1; ls_size = 2'd3; ls_addr = 32'h100;
        if_read_signal = 1'b1; if_pc = 32'h200;
        wait_done(1'b0, 6, 1'b1, 32'h0010_0513, "both_ls");
        check("both_if_quiet", if_done, 1'b0);
        ls_valid = 1'b0;
        wait_done(1'b1, 7, 1'b1, 32'hDEAD_BEEF, "both_if");
        if_read_signal = 1'b0; tick();

        // rdy_in low for 3 cycles during a word fetch
        if_pc = 32'h100; if_read_signal = 1'b1;
        tick(); tick();
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("gap_if_quiet", if_done, 1'b0);
        end
        rdy_in = 1'b1;
        wait_done(1'b1, 4, 1'b1, 32'h0010_0513, "gap_fetch");
        if_read_signal = 1'b0; tick();

        // Half store with a 2-cycle rdy gap
        ls_valid = 1'b1; ls_wr = 1'b1; ls_size = 2'd1;
        ls_addr = 32'h300; ls_wdata = 32'hFFFF_1234;
        tick();
        check("sg_wr_on", mem_wr, 1'b1);
        rdy_in = 1'b0;
        #1;
        check("sg_wr_gap", mem_wr, 1'b0);
        tick(); check("sg_wr_gap1", mem_wr, 1'b0);
        tick(); check("sg_wr_gap2", mem_wr, 1'b0);
        rdy_in = 1'b1;
        wait_done(1'b0, 2, 1'b0, 32'h0, "sg_done");
        ls_valid = 1'b0; tick();
        check("sg_ram0", ram[10'h300], 8'h34);
        check("sg_ram1", ram[10'h301], 8'h12);

        // Reset in cycle 3 of a word store
        ls_valid = 1'b1; ls_wr = 1'b1; ls_size = 2'd2;
        ls_addr = 32'h340; ls_wdata = 32'hCAFE_F00D;
        tick(); tick(); tick();
        rst_in = 1'b1; ls_valid = 1'b0;
        tick();
        rst_in = 1'b0;
        check("rs_wr", mem_wr, 1'b0);
        check("rs_a", mem_a, 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rs_no_done", ls_done, 1'b0);
            check("rs_no_wr", mem_wr, 1'b0);
        end
        check("rs_ram2", ram[10'h342], 8'hFE);
        check("rs_ram3", ram[10'h343], 8'h55);
        ls_valid = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h341;
        wait_done(1'b0, 3, 1'b1, 32'h0000_00F0, "rs_idle_ld");
        ls_valid = 1'b0; tick();

        // Reset overrides rdy_in low mid-fetch
        if_pc = 32'h200; if_read_signal = 1'b1;
        tick(); tick();
        rdy_in = 1'b0; rst_in = 1'b1; if_read_signal = 1'b0;
        tick();
        rst_in = 1'b0; rdy_in = 1'b1;
        check("ro_a", mem_a, 32'h0);
        check("ro_instr_clr", if_instr, 32'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("ro_no_done", if_done, 1'b0);
        end

        // Word fetch wrapping past 0xFFFFFFFF
        if_pc = 32'hFFFF_FFFE; if_read_signal = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("wrap_a", mem_a, wrap_a[k]);
        end
        wait_done(1'b1, 2, 1'b1, 32'hDDCC_BBAA, "wrap_fetch");
        if_read_signal = 1'b0; tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
